// File: rtl/cache_tag_lookup.sv
// cache_tag_lookup: N-way set-associative tag store with lookup, miss/refill
// handshake, round-robin victim selection and a one-set-per-cycle flush.
// The tag compare is done against the incoming address in the accept cycle,
// so every response field comes straight from a register in the LOOKUP cycle.
module cache_tag_lookup #(
    parameter  int ADDR_WIDTH  = 32,
    parameter  int N_WAYS      = 2,
    parameter  int BLOCK_SIZE  = 128,
    parameter  int NUM_SETS    = 32,
    localparam int OFFSET_BITS = $clog2(BLOCK_SIZE),
    localparam int INDEX_BITS  = $clog2(NUM_SETS),
    localparam int TAG_BITS    = ADDR_WIDTH - INDEX_BITS - OFFSET_BITS,
    localparam int WAY_BITS    = $clog2(N_WAYS)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [ADDR_WIDTH-1:0]  req_addr,
    output logic                   resp_valid,
    output logic                   resp_hit,
    output logic [WAY_BITS-1:0]    resp_way,
    output logic [TAG_BITS-1:0]    resp_tag,
    output logic [INDEX_BITS-1:0]  resp_index,
    output logic [OFFSET_BITS-1:0] resp_offset,
    output logic                   refill_req,
    output logic [WAY_BITS-1:0]    refill_way,
    output logic [INDEX_BITS-1:0]  refill_index,
    input  logic                   refill_done,
    input  logic                   flush_start,
    output logic                   flush_busy
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LOOKUP    = 2'd1,
        ST_MISS_WAIT = 2'd2,
        ST_FLUSH     = 2'd3
    } state_t;

    localparam logic [INDEX_BITS-1:0] FLUSH_LAST = INDEX_BITS'(NUM_SETS - 1);

    state_t                  state_q, state_d;

    // Tag store, per-set valid bits and per-set round-robin pointer
    logic [N_WAYS-1:0]       valid_q [NUM_SETS];
    logic [TAG_BITS-1:0]     tag_q   [NUM_SETS][N_WAYS];
    logic [WAY_BITS-1:0]     ptr_q   [NUM_SETS];

    logic [INDEX_BITS-1:0]   flush_cnt_q;
    logic                    flush_busy_q;

    logic                    resp_valid_q;
    logic                    resp_hit_q;
    logic [WAY_BITS-1:0]     resp_way_q;
    logic [TAG_BITS-1:0]     resp_tag_q;
    logic [INDEX_BITS-1:0]   resp_index_q;
    logic [OFFSET_BITS-1:0]  resp_offset_q;
    logic                    victim_from_ptr_q;

    logic                    refill_req_q;
    logic [WAY_BITS-1:0]     refill_way_q;
    logic [INDEX_BITS-1:0]   refill_index_q;

    // Address field split of the incoming request
    logic [TAG_BITS-1:0]     req_tag_s;
    logic [INDEX_BITS-1:0]   req_index_s;
    logic [OFFSET_BITS-1:0]  req_offset_s;

    assign req_tag_s    = req_addr[ADDR_WIDTH-1 -: TAG_BITS];
    assign req_index_s  = req_addr[OFFSET_BITS +: INDEX_BITS];
    assign req_offset_s = req_addr[OFFSET_BITS-1:0];

    // Lookup results for the incoming address
    logic                    lk_hit_s;
    logic [WAY_BITS-1:0]     lk_hit_way_s;
    logic                    inv_found_s;
    logic [WAY_BITS-1:0]     inv_way_s;
    logic [WAY_BITS-1:0]     victim_way_s;
    logic                    victim_from_ptr_s;

    // FSM control strobes
    logic                    accept_s;
    logic                    miss_s;
    logic                    fill_s;
    logic                    flush_step_s;
    logic                    enter_flush_s;
    logic                    flush_last_s;

    // Tag compare across all ways; scanning downwards leaves the lowest match/invalid way
    always_comb begin
        lk_hit_s     = 1'b0;
        lk_hit_way_s = '0;
        inv_found_s  = 1'b0;
        inv_way_s    = '0;
        for (int w = N_WAYS - 1; w >= 0; w--) begin
            lk_hit_way_s = (valid_q[req_index_s][w] && (tag_q[req_index_s][w] == req_tag_s))
                           ? WAY_BITS'(w) : lk_hit_way_s;
            lk_hit_s     = lk_hit_s | (valid_q[req_index_s][w] && (tag_q[req_index_s][w] == req_tag_s));
            inv_way_s    = (!valid_q[req_index_s][w]) ? WAY_BITS'(w) : inv_way_s;
            inv_found_s  = inv_found_s | !valid_q[req_index_s][w];
        end
    end

    assign victim_from_ptr_s = !inv_found_s;
    assign victim_way_s      = inv_found_s ? inv_way_s : ptr_q[req_index_s];
    assign flush_last_s      = (flush_cnt_q == FLUSH_LAST);

    // Next-state and control strobes
    always_comb begin
        state_d       = state_q;
        accept_s      = 1'b0;
        miss_s        = 1'b0;
        fill_s        = 1'b0;
        flush_step_s  = 1'b0;
        enter_flush_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (flush_start) begin
                    state_d       = ST_FLUSH;
                    enter_flush_s = 1'b1;
                end else if (req_valid) begin
                    state_d  = ST_LOOKUP;
                    accept_s = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (resp_hit_q) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_MISS_WAIT;
                    miss_s  = 1'b1;
                end
            end
            ST_MISS_WAIT: begin
                if (refill_done) begin
                    state_d = ST_IDLE;
                    fill_s  = 1'b1;
                end else begin
                    state_d = ST_MISS_WAIT;
                end
            end
            ST_FLUSH: begin
                flush_step_s = 1'b1;
                if (flush_last_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_FLUSH;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State register, response/refill/flush output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= ST_IDLE;
            resp_valid_q      <= 1'b0;
            resp_hit_q        <= 1'b0;
            resp_way_q        <= '0;
            resp_tag_q        <= '0;
            resp_index_q      <= '0;
            resp_offset_q     <= '0;
            victim_from_ptr_q <= 1'b0;
            refill_req_q      <= 1'b0;
            refill_way_q      <= '0;
            refill_index_q    <= '0;
            flush_busy_q      <= 1'b0;
            flush_cnt_q       <= '0;
        end else begin
            state_q      <= state_d;
            resp_valid_q <= accept_s;
            if (accept_s) begin
                resp_hit_q        <= lk_hit_s;
                resp_way_q        <= lk_hit_s ? lk_hit_way_s : victim_way_s;
                resp_tag_q        <= req_tag_s;
                resp_index_q      <= req_index_s;
                resp_offset_q     <= req_offset_s;
                victim_from_ptr_q <= victim_from_ptr_s;
            end
            if (miss_s) begin
                refill_req_q   <= 1'b1;
                refill_way_q   <= resp_way_q;
                refill_index_q <= resp_index_q;
            end else if (fill_s) begin
                refill_req_q <= 1'b0;
            end
            if (enter_flush_s) begin
                flush_busy_q <= 1'b1;
            end else if (flush_step_s && flush_last_s) begin
                flush_busy_q <= 1'b0;
            end
            if (flush_step_s) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    // Valid bits and replacement pointers: cleared by reset/flush, updated on fill
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else if (flush_step_s) begin
            valid_q[flush_cnt_q] <= '0;
            ptr_q[flush_cnt_q]   <= '0;
        end else if (fill_s) begin
            valid_q[refill_index_q][refill_way_q] <= 1'b1;
            if (victim_from_ptr_q) begin
                ptr_q[refill_index_q] <= ptr_q[refill_index_q] + 1'b1;
            end
        end
    end

    // Tag array write on fill; contents need no reset because valid bits gate them
    always_ff @(posedge clk) begin
        if (fill_s) begin
            tag_q[refill_index_q][refill_way_q] <= resp_tag_q;
        end
    end

    assign req_ready    = (state_q == ST_IDLE) && !flush_start;
    assign resp_valid   = resp_valid_q;
    assign resp_hit     = resp_hit_q;
    assign resp_way     = resp_way_q;
    assign resp_tag     = resp_tag_q;
    assign resp_index   = resp_index_q;
    assign resp_offset  = resp_offset_q;
    assign refill_req   = refill_req_q;
    assign refill_way   = refill_way_q;
    assign refill_index = refill_index_q;
    assign flush_busy   = flush_busy_q;

endmodule

// File: tb/tb_cache_tag_lookup.sv
// Directed bench for cache_tag_lookup with default geometry
// (offset 7 bits, index 5 bits, tag 20 bits, 2 ways, 32 sets).
module tb_cache_tag_lookup;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_hit;
    logic [0:0]  resp_way;
    logic [19:0] resp_tag;
    logic [4:0]  resp_index;
    logic [6:0]  resp_offset;
    logic        refill_req;
    logic [0:0]  refill_way;
    logic [4:0]  refill_index;
    logic        refill_done;
    logic        flush_start;
    logic        flush_busy;

    int checks = 0;
    int passed = 0;
    int busy_cycles;

    cache_tag_lookup dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .resp_valid   (resp_valid),
        .resp_hit     (resp_hit),
        .resp_way     (resp_way),
        .resp_tag     (resp_tag),
        .resp_index   (resp_index),
        .resp_offset  (resp_offset),
        .refill_req   (refill_req),
        .refill_way   (refill_way),
        .refill_index (refill_index),
        .refill_done  (refill_done),
        .flush_start  (flush_start),
        .flush_busy   (flush_busy)
    );

    always #5 clk = ~clk;

    // advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // issue one request; check the response pulse and the following cycle
    task automatic lookup(input string tag, input logic [31:0] addr,
                          input logic exp_hit, input logic [0:0] exp_way);
        req_addr  = addr;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_resp_hit"},   32'(resp_hit),   32'(exp_hit));
        chk({tag, "_resp_way"},   32'(resp_way),   32'(exp_way));
        step();
        chk({tag, "_resp_pulse_end"}, 32'(resp_valid), 32'd0);
        if (exp_hit) begin
            chk({tag, "_no_refill"}, 32'(refill_req), 32'd0);
            chk({tag, "_ready_after_hit"}, 32'(req_ready), 32'd1);
        end else begin
            chk({tag, "_refill_req"},   32'(refill_req),   32'd1);
            chk({tag, "_refill_way"},   32'(refill_way),   32'(exp_way));
            chk({tag, "_refill_index"}, 32'(refill_index), 32'(addr[11:7]));
        end
    endtask

    // hold off the fill for 'delay' cycles, then pulse refill_done
    task automatic fill(input string tag, input int delay);
        for (int i = 0; i < delay; i++) begin
            step();
            chk({tag, "_refill_held"}, 32'(refill_req), 32'd1);
        end
        refill_done = 1'b1;
        step();
        refill_done = 1'b0;
        chk({tag, "_refill_drop"}, 32'(refill_req), 32'd0);
        chk({tag, "_ready_after_fill"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        rst         = 1'b1;
        req_valid   = 1'b0;
        req_addr    = 32'h0;
        refill_done = 1'b0;
        flush_start = 1'b0;
        step();
        step();
        rst = 1'b0;

        // reset state
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_hit",   32'(resp_hit),   32'd0);
        chk("rst_resp_way",   32'(resp_way),   32'd0);
        chk("rst_resp_tag",   32'(resp_tag),   32'd0);
        chk("rst_refill_req", 32'(refill_req), 32'd0);
        chk("rst_refill_idx", 32'(refill_index), 32'd0);
        chk("rst_flush_busy", 32'(flush_busy), 32'd0);
        chk("rst_req_ready",  32'(req_ready),  32'd1);

        // field split on first miss: tag 1, set 4, offset 0x34
        req_addr  = 32'h0000_1234;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        chk("split_valid",  32'(resp_valid),  32'd1);
        chk("split_tag",    32'(resp_tag),    32'h1);
        chk("split_index",  32'(resp_index),  32'd4);
        chk("split_offset", 32'(resp_offset), 32'h34);
        chk("split_hit",    32'(resp_hit),    32'd0);
        chk("split_way",    32'(resp_way),    32'd0);
        chk("split_busy",   32'(req_ready),   32'd0);
        step();
        chk("split_refill_req", 32'(refill_req),   32'd1);
        chk("split_refill_idx", 32'(refill_index), 32'd4);
        chk("split_refill_way", 32'(refill_way),   32'd0);
        fill("split", 0);

        // hit on the freshly installed line
        lookup("hit1", 32'h0000_1234, 1'b1, 1'b0);

        // refill_done outside MISS_WAIT has no effect
        refill_done = 1'b1;
        step();
        refill_done = 1'b0;
        chk("stray_done_refill", 32'(refill_req), 32'd0);

        // invalid way 1 preferred over the pointer; fill held for 3 cycles
        lookup("inv_pref", 32'h0000_2234, 1'b0, 1'b1);
        fill("inv_pref", 3);
        lookup("hit_way1", 32'h0000_2234, 1'b1, 1'b1);

        // set full: pointer 0 picks way 0, then pointer moves to 1
        lookup("rr_first", 32'h0000_3234, 1'b0, 1'b0);
        fill("rr_first", 0);
        lookup("rr_second", 32'h0000_1234, 1'b0, 1'b1);
        fill("rr_second", 1);
        lookup("rr_keep", 32'h0000_3234, 1'b1, 1'b0);
        lookup("rr_new", 32'h0000_1234, 1'b1, 1'b1);

        // other set untouched: set 1 still empty
        lookup("set1_miss", 32'h0000_0080, 1'b0, 1'b0);
        fill("set1", 0);
        lookup("set1_hit", 32'h0000_00FF, 1'b1, 1'b0);

        // flush wins over a simultaneous request
        req_addr    = 32'h0000_3234;
        req_valid   = 1'b1;
        flush_start = 1'b1;
        #1;
        chk("flush_ready_low", 32'(req_ready), 32'd0);
        step();
        req_valid   = 1'b0;
        flush_start = 1'b0;
        chk("flush_no_accept", 32'(resp_valid), 32'd0);
        chk("flush_busy_on",   32'(flush_busy), 32'd1);
        busy_cycles = 0;
        while (flush_busy && busy_cycles < 100) begin
            busy_cycles++;
            step();
        end
        chk("flush_length", 32'(busy_cycles), 32'd32);
        chk("flush_ready_after", 32'(req_ready), 32'd1);
        lookup("post_flush", 32'h0000_3234, 1'b0, 1'b0);
        fill("post_flush", 0);
        lookup("post_flush_set1", 32'h0000_0080, 1'b0, 1'b0);
        fill("post_flush_set1", 0);

        // reset in the middle of a refill
        lookup("pre_rst", 32'h0000_5234, 1'b0, 1'b1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_refill", 32'(refill_req), 32'd0);
        chk("mid_rst_ready",  32'(req_ready),  32'd1);
        chk("mid_rst_way",    32'(refill_way), 32'd0);
        refill_done = 1'b1;
        step();
        refill_done = 1'b0;
        chk("mid_rst_done_ignored", 32'(refill_req), 32'd0);
        lookup("after_rst", 32'h0000_3234, 1'b0, 1'b0);
        fill("after_rst", 0);
        lookup("after_rst_set1", 32'h0000_0080, 1'b0, 1'b0);
        fill("after_rst_set1", 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/cache_tag_lookup.md
Name: cache_tag_lookup

Overview:
Parametrised N-way set-associative tag store and lookup controller for the cache front end. It accepts a request address, splits it into tag, index and offset fields derived from the cache geometry, and compares the tag against every way of the indexed set. It reports hit/way or miss/victim, and on a miss runs a refill handshake with the line-fill engine, then installs the new tag. It also provides a whole-cache invalidate (flush) sequence.

Parameters:
ADDR_WIDTH, 32, request address width
N_WAYS, 2, associativity; power of two, >=2
BLOCK_SIZE, 128, bytes per line; power of two
NUM_SETS, 32, sets; power of two, >=2
OFFSET_BITS, $clog2(BLOCK_SIZE), derived localparam, not overridable
INDEX_BITS, $clog2(NUM_SETS), derived localparam
TAG_BITS, ADDR_WIDTH-INDEX_BITS-OFFSET_BITS, derived localparam; must be >=1
WAY_BITS, $clog2(N_WAYS), derived localparam

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  1  lookup request valid
req_ready  out  1  lookup request can be accepted
req_addr  in  ADDR_WIDTH  request byte address
resp_valid  out  1  one-cycle pulse, lookup result valid
resp_hit  out  1  1 = hit, 0 = miss
resp_way  out  WAY_BITS  hit way, or victim way on a miss
resp_tag / resp_index / resp_offset  out  TAG_BITS / INDEX_BITS / OFFSET_BITS  fields of the accepted address
refill_req  out  1  line fill requested; held until refill_done
refill_way  out  WAY_BITS  way being filled
refill_index  out  INDEX_BITS  set being filled
refill_done  in  1  fill engine finished; install tag
flush_start  in  1  begin invalidate-all
flush_busy  out  1  flush in progress

Behaviour:
- Field split: tag = addr[ADDR_WIDTH-1 -: TAG_BITS]; index = next INDEX_BITS bits; offset = addr[OFFSET_BITS-1:0].
- Storage: per set and way, a valid bit and a TAG_BITS tag. Per set, a WAY_BITS round-robin pointer.
- States: IDLE, LOOKUP, MISS_WAIT, FLUSH.
- req_ready = (state==IDLE) && !flush_start. This is combinational.
- IDLE: flush_start=1 -> FLUSH; flush wins over a simultaneous req_valid, and the request is not accepted. Otherwise, if req_valid && req_ready: register the address and go to LOOKUP.
- LOOKUP (exactly one cycle; accept at T, resp_valid at T+1):
  - Hit: some way is valid with a matching tag. resp_hit=1, resp_way = that way (lowest index if duplicates). Go to IDLE. Replacement state is unchanged.
  - Miss: resp_hit=0. Victim = lowest-indexed invalid way. If all ways are valid, victim = the set's pointer. resp_way = victim. Go to MISS_WAIT.
- MISS_WAIT:
  - refill_req=1; refill_way and refill_index are held stable.
  - On refill_done: write the tag into the victim way and set its valid bit. If the victim came from the pointer, pointer <= pointer+1 mod N_WAYS; otherwise the pointer is unchanged.
  - refill_req drops the next cycle; go to IDLE.
  - refill_done is legal in the first MISS_WAIT cycle. refill_done in any other state is ignored.
- FLUSH:
  - A set counter starting at 0 clears every way's valid bit and the pointer of one set per cycle.
  - flush_busy=1 throughout. Exactly NUM_SETS cycles, then IDLE; the counter wraps to 0.
  - flush_start outside IDLE is ignored.
- Back-to-back: a new request can be accepted the cycle after a hit response (IDLE). Maximum throughput is one lookup per 2 cycles.
- Reset (any state, including mid-refill or mid-flush):
  - state=IDLE; all valid bits=0; all pointers=0; flush counter=0.
  - Outputs: resp_valid=0, resp_hit=0, resp_way=0, resp_tag/index/offset=0, refill_req=0, refill_way=0, refill_index=0, flush_busy=0. req_ready=1 in the first cycle after reset (unless flush_start).
  - Tag contents are don't-care after reset.

Test Plan:
(Defaults throughout: offset=7, index=5, tag=20 bits.)
- Field split: after reset, request 0x0000_1234 -> resp_valid one cycle later, resp_tag=1, resp_index=4, resp_offset=0x34, resp_hit=0, resp_way=0, refill_req=1 with refill_index=4. Pulse refill_done -> refill_req low the next cycle.
- Hit: repeat 0x0000_1234 -> resp_hit=1, resp_way=0, no refill_req.
- Invalid-way preference: 0x0000_2234 (tag 2, set 4) -> miss, resp_way=1. Fill; re-request gives hit on way 1.
- Round-robin eviction: 0x0000_3234 -> miss, victim way 0 (pointer 0); fill; pointer becomes 1. 0x0000_1234 now misses with victim way 1. 0x0000_3234 still hits way 0.
- Flush: in IDLE assert flush_start together with req_valid -> req_ready=0, request not accepted, flush_busy high for exactly 32 cycles. Then 0x0000_3234 misses with victim way 0.
- Reset mid-operation: assert rst during MISS_WAIT -> refill_req=0 next cycle, state IDLE. All prior hits now miss.
